// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating count of load-use stall cycles.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_wr,
  input  logic        id_mem_rd,
  input  logic        id_mem_wr,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_a,
  input  logic [31:0] id_b,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic        flush,
  input  logic        hold,
  output logic        id_ex_valid,
  output logic        id_ex_reg_wr,
  output logic        id_ex_mem_rd,
  output logic        id_ex_mem_wr,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [3:0]  id_ex_alu_op,
  output logic [31:0] id_ex_a,
  output logic [31:0] id_ex_b,
  output logic [31:0] id_ex_imm,
  output logic [31:0] id_ex_pc,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  rs;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
  } pipe_t;

  localparam int    PIPE_W = $bits(pipe_t);
  localparam pipe_t BUBBLE = pipe_t'({PIPE_W{1'b0}});

  pipe_t       pipe_r;
  pipe_t       pipe_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic        load_use_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  // Hazard: a load in EX writes a register that the instruction in ID reads.
  always_comb begin
    load_use_s = pipe_r.valid & pipe_r.mem_rd & (pipe_r.rd != 5'd0) & id_valid &
                 ((pipe_r.rd == id_rs) | (pipe_r.rd == id_rs2));
  end

  // Stall is purely combinational so upstream freezes in the same cycle.
  assign stall = load_use_s & ~flush;

  // Next-state selection: flush > hold > load_use > normal load.
  always_comb begin
    pipe_nxt_s = pipe_r;
    cnt_nxt_s  = cnt_r;
    if (flush) begin
      pipe_nxt_s = BUBBLE;
    end else if (hold) begin
      pipe_nxt_s = pipe_r;
      cnt_nxt_s  = cnt_r;
    end else if (load_use_s) begin
      pipe_nxt_s = BUBBLE;
      cnt_nxt_s  = sat_inc(cnt_r);
    end else begin
      pipe_nxt_s.valid  = id_valid;
      pipe_nxt_s.alu_op = id_alu_op;
      pipe_nxt_s.a      = id_a;
      pipe_nxt_s.b      = id_b;
      pipe_nxt_s.imm    = id_imm;
      pipe_nxt_s.pc     = id_pc;
      // An empty slot must not look like a writer or a source to forwarding.
      if (id_valid) begin
        pipe_nxt_s.reg_wr = id_reg_wr;
        pipe_nxt_s.mem_rd = id_mem_rd;
        pipe_nxt_s.mem_wr = id_mem_wr;
        pipe_nxt_s.rs     = id_rs;
        pipe_nxt_s.rs2    = id_rs2;
        pipe_nxt_s.rd     = id_rd;
      end else begin
        pipe_nxt_s.reg_wr = 1'b0;
        pipe_nxt_s.mem_rd = 1'b0;
        pipe_nxt_s.mem_wr = 1'b0;
        pipe_nxt_s.rs     = 5'd0;
        pipe_nxt_s.rs2    = 5'd0;
        pipe_nxt_s.rd     = 5'd0;
      end
    end
  end

  // Pipeline and stall-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_r <= BUBBLE;
      cnt_r  <= 16'd0;
    end else begin
      pipe_r <= pipe_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign id_ex_valid  = pipe_r.valid;
  assign id_ex_reg_wr = pipe_r.reg_wr;
  assign id_ex_mem_rd = pipe_r.mem_rd;
  assign id_ex_mem_wr = pipe_r.mem_wr;
  assign id_ex_rs     = pipe_r.rs;
  assign id_ex_rs2    = pipe_r.rs2;
  assign id_ex_rd     = pipe_r.rd;
  assign id_ex_alu_op = pipe_r.alu_op;
  assign id_ex_a      = pipe_r.a;
  assign id_ex_b      = pipe_r.b;
  assign id_ex_imm    = pipe_r.imm;
  assign id_ex_pc     = pipe_r.pc;
  assign stall_cnt    = cnt_r;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: id_valid  in  1  decode stage holds a real instruction.
REQ-003 SHALL have: id_rs, id_rs2, id_rd  in  5 each  decoded source/destination register numbers.
REQ-004 SHALL have: id_reg_wr, id_mem_rd, id_mem_wr  in  1 each  decoded control bits.
REQ-005 SHALL have: id_alu_op  in  4  ALU operation; id_a, id_b, id_imm, id_pc  in  32 each  operands, immediate, PC.
REQ-006 SHALL have: flush  in  1  branch/jump resolved taken in EX; hold  in  1  downstream memory stall, freezes stage.
REQ-007 SHALL have: id_ex_valid, id_ex_reg_wr, id_ex_mem_rd, id_ex_mem_wr  out  1 each  registered controls.
REQ-008 SHALL have: id_ex_rs, id_ex_rs2, id_ex_rd  out  5 each  registered register numbers (feed forwarding unit).
REQ-009 SHALL have: id_ex_alu_op  out  4; id_ex_a, id_ex_b, id_ex_imm, id_ex_pc  out  32 each  registered datapath fields.
REQ-010 SHALL have: stall  out  1  freeze PC and IF/ID (combinational); stall_cnt  out  16  load-use stall cycle count.

Function
REQ-011 SHALL compute load_use = id_ex_valid & id_ex_mem_rd & (id_ex_rd != 0) & id_valid & ((id_ex_rd == id_rs) | (id_ex_rd == id_rs2)), combinationally from current register state and ID inputs.
REQ-012 SHALL drive stall = load_use & ~flush; stall SHALL depend on no registered copy of itself (no extra latency).
REQ-013 SHALL, each rising clk, select next state by strict priority: flush > hold > load_use > normal load.
REQ-014 Flush: SHALL load a bubble (REQ-017) regardless of hold, load_use or id_valid.
REQ-015 Hold (no flush): SHALL keep every output register unchanged; stall_cnt unchanged.
REQ-016 Load_use (no flush, no hold): SHALL load a bubble and increment stall_cnt by 1.
REQ-017 Bubble SHALL set valid, reg_wr, mem_rd, mem_wr, rs, rs2, rd, alu_op, a, b, imm, pc all to 0.
REQ-018 Normal load: SHALL capture all id_* fields; id_ex_valid <= id_valid; if id_valid=0 the control bits reg_wr/mem_rd/mem_wr SHALL be forced 0 and rs/rs2/rd forced 0.
REQ-019 Latency: fields presented on ID in cycle N (normal load) SHALL appear on outputs after the edge ending cycle N, i.e. 1 cycle.
REQ-020 A load-use stall SHALL last exactly 1 cycle per offending pair: after the bubble, id_ex_mem_rd=0 so load_use deasserts while ID is still held.
REQ-021 stall_cnt SHALL saturate at 0xFFFF (no wrap); it SHALL never decrement.
REQ-022 Register 0 as id_ex_rd SHALL never cause a stall, even with mem_rd=1.
REQ-023 Hold concurrent with load_use SHALL keep stall=1 asserted for every held cycle, with no bubble and no count until hold drops.

Reset
REQ-024 While rst_n=0 all output registers SHALL be 0 (equivalent to a bubble) and stall_cnt SHALL be 0, taking effect immediately without a clock edge.
REQ-025 Reset asserted mid-stall SHALL clear state so that stall=0 in the same cycle (id_ex_valid=0); first edge after rst_n rises SHALL perform a normal load.

Verification
REQ-026 Normal: id_valid=1, rs=3, rs2=4, rd=5, reg_wr=1, a=0x11, b=0x22 -> next cycle id_ex_rd=5, id_ex_a=0x11, id_ex_b=0x22, id_ex_valid=1, stall=0.
REQ-027 Load-use: EX holds lw rd=7 (mem_rd=1, valid=1); ID presents rs=7 -> stall=1 same cycle; next edge id_ex_valid=0, id_ex_rd=0, stall_cnt=1; following cycle stall=0 and the instruction loads with rs=7.
REQ-028 r0 exemption: EX holds lw rd=0; ID rs=0 -> stall=0, normal load, stall_cnt unchanged.
REQ-029 Priority: load_use true and flush=1 in same cycle -> stall=0, bubble loaded, stall_cnt unchanged; hold=1 with load_use -> outputs frozen, stall=1 for 3 hold cycles, stall_cnt unchanged, then bubble and count +1 when hold=0.
REQ-030 Saturation: force 65,536 load-use stalls -> stall_cnt=0xFFFF and stays 0xFFFF on further stalls.
REQ-031 Async reset: during stall=1, drop rst_n between edges -> all outputs 0 and stall=0 immediately; release -> next edge loads ID fields normally.
